ahb_resp_ctrl: RTL

AHB_RESP_CTRL -- requirements
Module: ahb_resp_ctrl

---
 rtl/ahb_resp_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ahb_resp_ctrl.sv
// ahb_resp_ctrl -- AHB-Lite slave response controller.
//
// Decodes a 4-bit region index from HADDR, checks each accepted transfer
// (region range, HSIZE, write protection) and shapes the data-phase response:
// a programmable number of wait states (extendable by a backend stall) for
// legal transfers, or the two-cycle AHB ERROR response for illegal ones.
//
// Ports
//   HCLK, HRESET         clock, asynchronous active-high reset
//   HSEL .. HREADY       AHB-Lite slave address-phase inputs
//   HREADYOUT, HRESP     data-phase response (HRESP: 0 OKAY, 1 ERROR)
//   wait_cfg             per-region wait count, region r at [r*WAIT_WIDTH +: WAIT_WIDTH]
//   region_ro            per-region write protect
//   stall_i              holds the final wait cycle while high
//   done_o               one-cycle pulse when a legal data phase completes
//   dp_addr_o/dp_write_o/dp_region_o  captured address-phase info of the current data phase
//   err_cnt_o            saturating count of ERROR responses
module ahb_resp_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGIONS = 4,
    parameter int REGION_LSB  = 12,
    parameter int WAIT_WIDTH  = 4,
    parameter int MAX_SIZE    = 2
) (
    input  logic                              HCLK,
    input  logic                              HRESET,
    input  logic                              HSEL,
    input  logic [ADDR_WIDTH-1:0]             HADDR,
    input  logic [1:0]                        HTRANS,
    input  logic                              HWRITE,
    input  logic [2:0]                        HSIZE,
    input  logic                              HREADY,
    output logic                              HREADYOUT,
    output logic                              HRESP,
    input  logic [NUM_REGIONS*WAIT_WIDTH-1:0] wait_cfg,
    input  logic [NUM_REGIONS-1:0]            region_ro,
    input  logic                              stall_i,
    output logic                              done_o,
    output logic [ADDR_WIDTH-1:0]             dp_addr_o,
    output logic                              dp_write_o,
    output logic [3:0]                        dp_region_o,
    output logic [7:0]                        err_cnt_o
);

    typedef enum logic [1:0] {IDLE, NOT_READY, ERR1, ERR2} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [3:0]            region;
    } dp_req_t;

    state_t                state, state_nxt;
    logic [WAIT_WIDTH-1:0] cnt, cnt_nxt;
    logic                  pend, pend_nxt;   // a legal data phase is outstanding
    dp_req_t               dp;

    logic                  rdy;
    logic                  accept;
    logic [3:0]            idx;
    logic [WAIT_WIDTH-1:0] wsel;
    logic                  ro_hit;
    logic                  idx_bad, size_bad, xfer_err;

    // HTRANS[0] only separates NONSEQ from SEQ, which respond identically.
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    assign idx = HADDR[REGION_LSB +: 4];
    assign rdy = (state == IDLE) || (state == ERR2);

    // Acceptance is also gated by our own ready so a protocol-violating
    // HREADY=1 in the middle of our data phase cannot restart the FSM.
    assign accept = HSEL & HTRANS[1] & HREADY & rdy;

    // Region lookup; out-of-range indices select nothing (flagged below).
    always_comb begin
        wsel   = '0;
        ro_hit = 1'b0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (idx == 4'(r)) begin
                wsel   = wait_cfg[r*WAIT_WIDTH +: WAIT_WIDTH];
                ro_hit = region_ro[r];
            end
        end
    end

    assign idx_bad  = {1'b0, idx} >= 5'(NUM_REGIONS);
    assign size_bad = HSIZE > 3'(MAX_SIZE);
    assign xfer_err = idx_bad | size_bad | (HWRITE & ro_hit);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        case (state)
            IDLE, ERR2: begin
                // Completion cycle of any previous phase: fall back to IDLE
                // unless a new transfer is accepted right here.
                state_nxt = IDLE;
                pend_nxt  = 1'b0;
                cnt_nxt   = '0;
                if (accept) begin
                    if (xfer_err) begin
                        state_nxt = ERR1;
                    end else begin
                        pend_nxt = 1'b1;
                        if (wsel != '0) begin
                            state_nxt = NOT_READY;
                            cnt_nxt   = wsel;   // wait count frozen at acceptance
                        end
                    end
                end
            end
            NOT_READY: begin
                if (cnt > WAIT_WIDTH'(1)) begin
                    cnt_nxt = cnt - WAIT_WIDTH'(1);
                end else if (!stall_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            ERR1:    state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp <= '0;
        end else if (accept) begin
            dp <= '{addr: HADDR, write: HWRITE, region: idx};
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_cnt_o <= '0;
        end else if (accept && xfer_err && err_cnt_o != 8'hFF) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

    assign HREADYOUT   = rdy;
    assign HRESP       = (state == ERR1) || (state == ERR2);
    assign done_o      = pend && (state == IDLE);
    assign dp_addr_o   = dp.addr;
    assign dp_write_o  = dp.write;
    assign dp_region_o = dp.region;

endmodule
